// File: rtl/mem_bus_arbiter_pkg.sv
// Shared encodings for the two-master external memory bus arbiter.
package mem_bus_pkg;

    localparam logic [1:0] BURST_SINGLE = 2'b00;
    localparam logic [1:0] BURST_INCR   = 2'b01;
    localparam logic [1:0] BURST_WRAP   = 2'b10;

    localparam int DEFAULT_BURST_LEN = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } bus_state_e;

endpackage

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the master that did not own the bus last wins.
module rr_arb2 (
    input  logic req0,
    input  logic req1,
    input  logic last_owner,
    output logic gnt_vld,
    output logic gnt_idx
);

    always_comb begin
        gnt_vld = req0 | req1;
        gnt_idx = (req0 & req1) ? ~last_owner : req1;
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Round-robin arbiter for the shared memory bus between I$ (M0) and D$ (M1) refill ports.
// Optional ACK timeout abort is compiled in with BUS_TIMEOUT_EN.
module mem_bus_arbiter
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int BURST_LEN      = DEFAULT_BURST_LEN,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [1:0]        m0_burst,
    input  logic              m0_wrb,
    input  logic [DATA_W-1:0] m0_wdata,
    input  logic [3:0]        m0_bstrobe,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    output logic              m0_stall,
    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [1:0]        m1_burst,
    input  logic              m1_wrb,
    input  logic [DATA_W-1:0] m1_wdata,
    input  logic [3:0]        m1_bstrobe,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
    output logic              m1_stall,
    output logic [ADDR_W-1:0] s_addr,
    output logic [1:0]        s_burst,
    output logic              s_req,
    output logic              s_wrb,
    output logic [DATA_W-1:0] s_wdata,
    output logic [3:0]        s_bstrobe,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_ack,
    input  logic              s_stall,
    output logic              bus_err
);

    localparam int CNT_W = $clog2(BURST_LEN) + 1;

    bus_state_e               state;
    logic                     last_owner;
    logic [CNT_W-1:0]         beat_cnt;
    logic                     is_burst;

    logic [1:0]               m_req;
    logic [1:0][ADDR_W-1:0]   m_addr;
    logic [1:0][1:0]          m_burst;
    logic [1:0]               m_wrb;
    logic [1:0][DATA_W-1:0]   m_wdata;
    logic [1:0][3:0]          m_bstrobe;
    logic [1:0]               m_ack;
    logic [1:0]               m_stall;

    logic owned, own, gnt_vld, gnt_idx;
    logic beat_done, last_beat, timeout_hit;

    assign m_req     = {m1_req, m0_req};
    assign m_addr    = {m1_addr, m0_addr};
    assign m_burst   = {m1_burst, m0_burst};
    assign m_wrb     = {m1_wrb, m0_wrb};
    assign m_wdata   = {m1_wdata, m0_wdata};
    assign m_bstrobe = {m1_bstrobe, m0_bstrobe};

    assign owned     = (state != IDLE);
    assign own       = (state == OWN1);
    assign beat_done = owned & s_ack & ~s_stall;
    assign last_beat = ~is_burst | (beat_cnt == CNT_W'(BURST_LEN - 1));

    rr_arb2 u_rr (
        .req0      (m0_req),
        .req1      (m1_req),
        .last_owner(last_owner),
        .gnt_vld   (gnt_vld),
        .gnt_idx   (gnt_idx)
    );

    // Slave side follows the owner combinationally; IDLE drives the reset values.
    always_comb begin
        s_req     = 1'b0;
        s_addr    = '0;
        s_burst   = BURST_SINGLE;
        s_wrb     = 1'b0;
        s_wdata   = '0;
        s_bstrobe = '0;
        if (owned) begin
            s_req     = m_req[own];
            s_addr    = m_addr[own];
            s_burst   = m_burst[own];
            s_wrb     = m_wrb[own];
            s_wdata   = m_wdata[own];
            s_bstrobe = m_bstrobe[own];
        end
    end

    for (genvar i = 0; i < 2; i++) begin : g_mst
        logic is_own;
        assign is_own     = owned && (own == 1'(i));
        assign m_ack[i]   = is_own & s_ack;
        assign m_stall[i] = ~is_own | s_stall;
    end

    assign m0_ack   = m_ack[0];
    assign m1_ack   = m_ack[1];
    assign m0_stall = m_stall[0];
    assign m1_stall = m_stall[1];
    assign m0_rdata = s_rdata;
    assign m1_rdata = s_rdata;

`ifdef BUS_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES) + 1;
    logic [TO_W-1:0] wait_cnt;

    assign timeout_hit = owned & s_req & ~beat_done &
                         (wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));

    // bus_err lands in the same cycle the bus goes back to IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
            bus_err  <= 1'b0;
        end else begin
            bus_err <= timeout_hit;
            if (!owned || beat_done || timeout_hit)
                wait_cnt <= '0;
            else if (s_req)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
    assign bus_err     = 1'b0;
`endif

    // Every ownership ends via IDLE, which gives the slave a dead slot with s_req low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            beat_cnt   <= '0;
            is_burst   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    beat_cnt <= '0;
                    if (gnt_vld) begin
                        state    <= gnt_idx ? OWN1 : OWN0;
                        is_burst <= (m_burst[gnt_idx] == BURST_INCR);
                    end
                end
                default: begin
                    if (!m_req[own] || timeout_hit) begin
                        state      <= IDLE;
                        last_owner <= own;
                    end else if (beat_done) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (last_beat) begin
                            state      <= IDLE;
                            last_owner <= own;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; the timeout scenario switches on BUS_TIMEOUT_EN.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        m0_req, m0_wrb, m1_req, m1_wrb;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [1:0]  m0_burst, m1_burst;
    logic [3:0]  m0_bstrobe, m1_bstrobe;
    logic [31:0] m0_rdata, m1_rdata;
    logic        m0_ack, m0_stall, m1_ack, m1_stall;
    logic [31:0] s_addr, s_wdata, s_rdata;
    logic [1:0]  s_burst;
    logic        s_req, s_wrb, s_ack, s_stall, bus_err;
    logic [3:0]  s_bstrobe;

    int tests = 0;
    int fails = 0;

    mem_bus_arbiter #(
        .ADDR_W(32), .DATA_W(32), .BURST_LEN(8), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_addr(m0_addr), .m0_burst(m0_burst), .m0_wrb(m0_wrb),
        .m0_wdata(m0_wdata), .m0_bstrobe(m0_bstrobe), .m0_rdata(m0_rdata),
        .m0_ack(m0_ack), .m0_stall(m0_stall),
        .m1_req(m1_req), .m1_addr(m1_addr), .m1_burst(m1_burst), .m1_wrb(m1_wrb),
        .m1_wdata(m1_wdata), .m1_bstrobe(m1_bstrobe), .m1_rdata(m1_rdata),
        .m1_ack(m1_ack), .m1_stall(m1_stall),
        .s_addr(s_addr), .s_burst(s_burst), .s_req(s_req), .s_wrb(s_wrb),
        .s_wdata(s_wdata), .s_bstrobe(s_bstrobe), .s_rdata(s_rdata),
        .s_ack(s_ack), .s_stall(s_stall), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        m0_req = 0; m0_addr = 0; m0_burst = 0; m0_wrb = 0; m0_wdata = 0; m0_bstrobe = 0;
        m1_req = 0; m1_addr = 0; m1_burst = 0; m1_wrb = 0; m1_wdata = 0; m1_bstrobe = 0;
        s_rdata = 0; s_ack = 0; s_stall = 0;
        #2;
        chk("rst_sreq", s_req, 0);
        chk("rst_saddr", s_addr, 0);
        chk("rst_m0stall", m0_stall, 1);
        chk("rst_m1stall", m1_stall, 1);
        chk("rst_buserr", bus_err, 0);
        nxt(); nxt();
        rst_n = 1'b1;

        // Tie from reset: M0 first, dead slot, then M1; next tie returns to M0
        m0_req = 1; m0_addr = 32'h1000; m0_bstrobe = 4'hF;
        m1_req = 1; m1_addr = 32'h2000; m1_wrb = 1; m1_wdata = 32'hDEAD_BEEF; m1_bstrobe = 4'h3;
        #1;
        chk("tie_latency_sreq", s_req, 0);
        nxt();
        chk("tie_m0_addr", s_addr, 32'h1000);
        chk("tie_m0_sreq", s_req, 1);
        chk("tie_m1_stall", m1_stall, 1);
        s_ack = 1; s_rdata = 32'hA5; #1;
        chk("tie_m0_ack", m0_ack, 1);
        chk("tie_m0_rdata", m0_rdata, 32'hA5);
        chk("tie_m1_ack", m1_ack, 0);
        nxt();
        m0_req = 0; s_ack = 0; #1;
        chk("tie_dead_sreq", s_req, 0);
        chk("tie_dead_m0stall", m0_stall, 1);
        nxt();
        chk("tie_m1_addr", s_addr, 32'h2000);
        chk("tie_m1_wrb", s_wrb, 1);
        chk("tie_m1_wdata", s_wdata, 32'hDEAD_BEEF);
        chk("tie_m1_bstrobe", s_bstrobe, 4'h3);
        s_ack = 1; #1;
        chk("tie_m1_ack", m1_ack, 1);
        chk("tie_m1_m0ack", m0_ack, 0);
        chk("tie_m1_m0stall", m0_stall, 1);
        nxt();
        m0_req = 1; s_ack = 0; #1;
        chk("tie2_dead_sreq", s_req, 0);
        nxt();
        chk("tie2_m0_first", s_addr, 32'h1000);
        s_ack = 1; #1;
        nxt();
        m0_req = 0; s_ack = 0;
        nxt();
        chk("tie2_m1_second", s_addr, 32'h2000);
        s_ack = 1; #1;
        chk("tie2_m1_ack", m1_ack, 1);
        nxt();
        m1_req = 0; m1_wrb = 0; s_ack = 0;
        nxt();

        // M0 INCR read, 8 back-to-back acks
        m0_req = 1; m0_burst = 2'b01; m0_addr = 32'h0; #1;
        chk("incr_latency_sreq", s_req, 0);
        nxt();
        chk("incr_sreq", s_req, 1);
        chk("incr_sburst", s_burst, 2'b01);
        for (int k = 0; k < 8; k++) begin
            s_ack = 1; s_rdata = 32'h100 + k; #1;
            chk("incr_m0_ack", m0_ack, 1);
            chk("incr_m0_rdata", m0_rdata, 32'h100 + k);
            chk("incr_m1_stall", m1_stall, 1);
            nxt();
        end
        s_ack = 0; #1;
        chk("incr_end_dead_sreq", s_req, 0);
        m0_req = 0;
        nxt();

        // M1 INCR with stall on beats 3-4
        m1_req = 1; m1_burst = 2'b01; m1_addr = 32'h3000;
        nxt();
        for (int i = 0; i < 10; i++) begin
            s_ack = 1; s_stall = (i == 2 || i == 3); #1;
            chk("stall_m1_ack", m1_ack, 1);
            chk("stall_m1_stall", m1_stall, (i == 2 || i == 3));
            chk("stall_m0_stall", m0_stall, 1);
            chk("stall_saddr", s_addr, 32'h3000);
            nxt();
        end
        s_ack = 0; s_stall = 0; #1;
        chk("stall_end_sreq", s_req, 0);
        m1_req = 0;
        nxt();

        // M0 burst aborted after beat 4 while M1 waits
        m0_req = 1; m0_burst = 2'b01; m0_addr = 32'h4000;
        nxt();
        m1_req = 1; m1_addr = 32'h5000; m1_burst = 2'b00;
        for (int k = 0; k < 4; k++) begin
            s_ack = 1; #1;
            chk("abort_m0_ack", m0_ack, 1);
            chk("abort_m1_ack", m1_ack, 0);
            chk("abort_saddr", s_addr, 32'h4000);
            nxt();
        end
        m0_req = 0; s_ack = 0; #1;
        chk("abort_drop_sreq", s_req, 0);
        nxt();
        chk("abort_idle_sreq", s_req, 0);
        chk("abort_idle_m1stall", m1_stall, 1);
        nxt();
        chk("abort_m1_granted", s_addr, 32'h5000);
        chk("abort_m1_sreq", s_req, 1);
        chk("abort_m1_stall", m1_stall, 0);
        s_ack = 1; #1;
        chk("abort_m1_ack", m1_ack, 1);
        nxt();
        m1_req = 0; s_ack = 0;
        nxt();

        // Async reset during beat 5, then a full fresh burst
        m0_req = 1; m0_burst = 2'b01; m0_addr = 32'h6000;
        nxt();
        for (int k = 0; k < 4; k++) begin
            s_ack = 1; #1;
            nxt();
        end
        s_ack = 1; #1;
        chk("mrst_beat5_ack", m0_ack, 1);
        rst_n = 0; #1;
        chk("mrst_sreq", s_req, 0);
        chk("mrst_saddr", s_addr, 0);
        chk("mrst_sburst", s_burst, 0);
        chk("mrst_m0ack", m0_ack, 0);
        chk("mrst_m0stall", m0_stall, 1);
        chk("mrst_m1stall", m1_stall, 1);
        nxt(); nxt();
        s_ack = 0; rst_n = 1; #1;
        chk("mrst_release_sreq", s_req, 0);
        nxt();
        chk("mrst_regrant_addr", s_addr, 32'h6000);
        for (int k = 0; k < 8; k++) begin
            s_ack = 1; #1;
            chk("mrst_full_ack", m0_ack, 1);
            nxt();
        end
        s_ack = 0; #1;
        chk("mrst_end_sreq", s_req, 0);
        m0_req = 0;
        nxt();

        // M1 never acked while M0 waits
        m1_req = 1; m1_burst = 2'b00; m1_addr = 32'h7000;
        nxt();
        m0_req = 1; m0_burst = 2'b00; m0_addr = 32'h8000;
`ifdef BUS_TIMEOUT_EN
        for (int i = 0; i < 16; i++) begin
            #1;
            chk("to_wait_buserr", bus_err, 0);
            chk("to_wait_sreq", s_req, 1);
            nxt();
        end
        chk("to_buserr_pulse", bus_err, 1);
        chk("to_sreq_drop", s_req, 0);
        m1_req = 0;
        nxt();
        chk("to_buserr_clear", bus_err, 0);
        chk("to_m0_granted", s_addr, 32'h8000);
`else
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("hang_buserr", bus_err, 0);
            chk("hang_sreq", s_req, 1);
            nxt();
        end
        m1_req = 0; #1;
        chk("hang_abort_sreq", s_req, 0);
        nxt();
        chk("hang_idle_buserr", bus_err, 0);
        nxt();
        chk("hang_m0_granted", s_addr, 32'h8000);
`endif
        s_ack = 1; #1;
        chk("final_m0_ack", m0_ack, 1);
        nxt();
        m0_req = 0; s_ack = 0;
        nxt();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-master arbiter for the shared external memory bus (ADDR/BURST/REQ/WRB/WDATA/RDATA/ACK/STALL/BSTROBE) between the instruction-cache refill port (M0) and the data-cache refill/writeback port (M1). It sits between mem_hier's cache controllers and the memory macro/slave. Ownership is locked for a whole transaction: one beat for a single transfer, BURST_LEN beats for INCR. Arbitration is round-robin.

Parameters:
ADDR_W, 32, bus address width
DATA_W, 32, bus data width
BURST_LEN, 8, beats per INCR burst (BURST=2'b01)
TIMEOUT_CYCLES, 256, ACK-less cycles before abort (BUS_TIMEOUT_EN only)

Ports:
clk  in  1  bus clock
rst_n  in  1  asynchronous active-low reset
mN_req  in  1  master N request, N=0,1; held until transaction done
mN_addr  in  ADDR_W  master N start address
mN_burst  in  2  00 single, 01 INCR, 10/11 treated as single
mN_wrb  in  1  master N write enable
mN_wdata  in  DATA_W  master N write data
mN_bstrobe  in  4  master N byte strobes
mN_rdata  out  DATA_W  read data, RDATA fanned out
mN_ack  out  1  beat acknowledge, owner only
mN_stall  out  1  stall to master N
s_addr,s_burst,s_req,s_wrb,s_wdata,s_bstrobe  out  as master  slave-side bus
s_rdata  in  DATA_W  slave read data
s_ack  in  1  slave beat acknowledge
s_stall  in  1  slave stall
bus_err  out  1  timeout pulse (BUS_TIMEOUT_EN only, else tied 0)

Behaviour:
- FSM states: IDLE, OWN0, OWN1. Registers: owner, last_owner (reset 1, so M0 wins the first tie), beat_cnt ($clog2(BURST_LEN)+1 bits), is_burst.
- Reset (async, all outputs): s_req=0, s_addr/s_wdata=0, s_burst=00, s_wrb=0, s_bstrobe=0, mN_ack=0, mN_stall=1, bus_err=0, state IDLE, beat_cnt=0.
- IDLE: if only one mN_req is high, grant that master. If both are high, grant the master != last_owner. The grant is registered, so s_req rises 1 cycle after mN_req (arbitration latency 1). is_burst is latched as (mN_burst==01). beat_cnt is cleared.
- OWNn: slave outputs are a combinational mux of master n, and s_req=mn_req. mn_ack=s_ack, mn_stall=s_stall, mn_rdata=s_rdata. The non-owner has ack=0 and stall=1. In IDLE both stalls=1 and both acks=0.
- Beat counting: a beat completes on s_ack & ~s_stall, and beat_cnt increments by 1.
- End of a single transfer: first completed beat.
- End of a burst: completed beat with beat_cnt==BURST_LEN-1.
- On completion: go to IDLE, set last_owner=n, then re-arbitrate next cycle. There is a 1-cycle dead slot with s_req=0, which also clears slave ACK handling.
- Owner drops mn_req mid-transaction: abort. Go to IDLE next cycle with s_req=0 in that cycle; last_owner=n.
- Request by the non-owner during OWN: ignored until IDLE. No preemption.
- s_stall high: beat not counted and no state change.
- mN_burst/addr changing while owned: not permitted (master holds stable); the arbiter is not required to detect it.
- Simultaneous completion and a new request from the same master: still passes through IDLE; round-robin then favours the other master if it is requesting.

Optional Feature:
BUS_TIMEOUT_EN:
- Defined: a wait counter counts owned cycles with s_req=1 and no completed beat. It is cleared on each completed beat.
- At TIMEOUT_CYCLES: bus_err pulses 1 cycle, the FSM forces IDLE, s_req drops, and last_owner updates.
- Undefined: no counter, and bus_err is tied 0.

Decomposition:
- Package mem_bus_pkg holds:
  - BURST_SINGLE=2'b00, BURST_INCR=2'b01, BURST_WRAP=2'b10;
  - the state encoding (IDLE=2'd0, OWN0=2'd1, OWN1=2'd2);
  - the default BURST_LEN.
- One natural sub-module, rr_arb2: a 2-input round-robin pick from (req0, req1, last_owner), combinational, returning the grant index.
- The mux and FSM stay in the top module.

Test Plan:
- M0 INCR read at 0x0000_0000, slave acks 8 consecutive cycles -> s_req high 1 cycle after m0_req; m0_ack x8; IDLE after beat 8; m1_stall=1 throughout.
- m0_req and m1_req single reads raised in the same cycle from reset -> M0 served first (1 ack), dead cycle, then M1; next tie goes to M0 again.
- M1 INCR with s_stall high on beats 3-4 -> beat_cnt holds, 8 acks still counted exactly, and the transaction ends only after the 8th unstalled ack.
- M0 burst with m0_req dropped after beat 4 -> IDLE next cycle, s_req=0, and a pending M1 is granted the following cycle.
- rst_n pulled low mid-burst (beat 5) -> all outputs at reset values asynchronously; after release, a fresh arbitration starts with beat_cnt=0.
- BUS_TIMEOUT_EN with TIMEOUT_CYCLES=16, M1 request, slave never acks -> bus_err pulses in cycle 16 of waiting, s_req drops, and a pending M0 is granted next.
